// File: rtl/lms_conv_monitor.sv
// Windowed mean-square-error monitor for the LMS filter error stream, with a
// hysteretic lock state machine (WARMUP -> UNLOCKED <-> LOCKED).
module lms_conv_monitor #(
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned SKIP_WIN = 4,
  parameter int unsigned LOCK_WIN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        en,
  input  logic [15:0] e,
  input  logic [31:0] thr_lock,
  input  logic [31:0] thr_unlock,
  output logic [31:0] mse,
  output logic        mse_valid,
  output logic        converged,
  output logic        lock_lost,
  output logic [1:0]  state,
  output logic [15:0] win_count
);

  localparam int unsigned AccW = 32 + WIN_LOG2;
  localparam logic [15:0] SkipW = 16'(SKIP_WIN);
  localparam logic [15:0] LockW = 16'(LOCK_WIN);

  typedef enum logic [1:0] {
    StWarmup   = 2'd0,
    StUnlocked = 2'd1,
    StLocked   = 2'd2
  } state_e;

  localparam state_e StInit = (SKIP_WIN == 0) ? StUnlocked : StWarmup;

  logic signed [31:0] e_ext;
  logic [31:0]        sq_q;
  logic               sq_v_q;

  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [AccW-1:0]     acc_q, acc_d, acc_sum;
  logic [31:0]         mse_q, mse_d, mse_new;
  logic                mse_valid_q, mse_valid_d;
  logic                lock_lost_q, lock_lost_d;
  state_e              state_q, state_d;
  logic [15:0]         win_q, win_d;
  logic [15:0]         skip_q, skip_d;
  logic [15:0]         lock_q, lock_d;

  assign e_ext = 32'(signed'(e));

  // Stage 1: square the error sample; |e|^2 <= 2^30 always fits.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      sq_v_q <= 1'b0;
      sq_q   <= '0;
    end else begin
      sq_v_q <= en;
      if (en) begin
        sq_q <= e_ext * e_ext;
      end
    end
  end

  assign acc_sum = acc_q + AccW'(sq_q);
  assign mse_new = acc_sum[WIN_LOG2 +: 32];

  // Stage 2: accumulate, close windows and step the lock FSM on each close.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mse_d       = mse_q;
    mse_valid_d = 1'b0;
    lock_lost_d = 1'b0;
    state_d     = state_q;
    win_d       = win_q;
    skip_d      = skip_q;
    lock_d      = lock_q;

    if (restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      state_d = StInit;
      win_d   = '0;
      skip_d  = '0;
      lock_d  = '0;
    end else if (sq_v_q) begin
      if (&cnt_q) begin
        cnt_d       = '0;
        acc_d       = '0;
        mse_d       = mse_new;
        mse_valid_d = 1'b1;
        win_d       = (win_q == 16'hFFFF) ? win_q : win_q + 16'd1;
        unique case (state_q)
          StWarmup: begin
            skip_d = skip_q + 16'd1;
            if (skip_d == SkipW) begin
              state_d = StUnlocked;
              lock_d  = '0;
            end
          end
          StUnlocked: begin
            lock_d = (mse_new < thr_lock) ? lock_q + 16'd1 : 16'd0;
            if (lock_d == LockW) begin
              state_d = StLocked;
              lock_d  = '0;
            end
          end
          StLocked: begin
            if (mse_new > thr_unlock) begin
              state_d     = StUnlocked;
              lock_d      = '0;
              lock_lost_d = 1'b1;
            end
          end
          default: state_d = StInit;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      mse_q       <= '0;
      mse_valid_q <= 1'b0;
      lock_lost_q <= 1'b0;
      state_q     <= StInit;
      win_q       <= '0;
      skip_q      <= '0;
      lock_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mse_q       <= mse_d;
      mse_valid_q <= mse_valid_d;
      lock_lost_q <= lock_lost_d;
      state_q     <= state_d;
      win_q       <= win_d;
      skip_q      <= skip_d;
      lock_q      <= lock_d;
    end
  end

  assign mse       = mse_q;
  assign mse_valid = mse_valid_q;
  assign converged = (state_q == StLocked);
  assign lock_lost = lock_lost_q;
  assign state     = state_q;
  assign win_count = win_q;

endmodule

// File: tb/tb_lms_conv_monitor.sv
// Bench for lms_conv_monitor: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a sample-list reference model.
module tb_lms_conv_monitor;

  localparam int WinLen  = 16;
  localparam int SkipWin = 4;
  localparam int LockWin = 3;

  logic        clk;
  logic        reset;
  logic        restart;
  logic        en;
  logic [15:0] e;
  logic [31:0] thr_lock;
  logic [31:0] thr_unlock;
  logic [31:0] mse;
  logic        mse_valid;
  logic        converged;
  logic        lock_lost;
  logic [1:0]  state;
  logic [15:0] win_count;

  lms_conv_monitor #(
    .WIN_LOG2(4),
    .SKIP_WIN(SkipWin),
    .LOCK_WIN(LockWin)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .en        (en),
    .e         (e),
    .thr_lock  (thr_lock),
    .thr_unlock(thr_unlock),
    .mse       (mse),
    .mse_valid (mse_valid),
    .converged (converged),
    .lock_lost (lock_lost),
    .state     (state),
    .win_count (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Reference model: expected outputs after each clock edge.
  longint      m_sum;
  int          m_n;
  logic [31:0] m_mse;
  bit          m_valid;
  bit          m_lost;
  int          m_state;
  int          m_win;
  int          m_skip;
  int          m_lock;
  bit          pend_v;
  longint      pend_sq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_close(input logic [31:0] m);
    case (m_state)
      0: begin
        m_skip++;
        if (m_skip >= SkipWin) begin
          m_state = 1;
          m_lock  = 0;
        end
      end
      1: begin
        if (m < thr_lock) m_lock++;
        else m_lock = 0;
        if (m_lock >= LockWin) begin
          m_state = 2;
          m_lock  = 0;
        end
      end
      default: begin
        if (m > thr_unlock) begin
          m_state = 1;
          m_lock  = 0;
          m_lost  = 1'b1;
        end
      end
    endcase
  endtask

  task automatic model_update(input bit r, input bit rs, input bit v, input logic [15:0] d);
    longint es;
    if (r || rs) begin
      m_sum   = 0;
      m_n     = 0;
      m_skip  = 0;
      m_lock  = 0;
      m_win   = 0;
      m_state = (SkipWin == 0) ? 1 : 0;
      m_valid = 1'b0;
      m_lost  = 1'b0;
      pend_v  = 1'b0;
      if (r) m_mse = 0;
    end else begin
      m_valid = 1'b0;
      m_lost  = 1'b0;
      if (pend_v) begin
        m_sum += pend_sq;
        m_n++;
        if (m_n == WinLen) begin
          m_mse   = 32'(m_sum / WinLen);
          m_sum   = 0;
          m_n     = 0;
          m_valid = 1'b1;
          if (m_win < 65535) m_win++;
          model_close(m_mse);
        end
      end
      es      = longint'($signed(d));
      pend_v  = v;
      pend_sq = es * es;
    end
  endtask

  task automatic step(input bit r, input bit rs, input bit v, input logic [15:0] d);
    reset   = r;
    restart = rs;
    en      = v;
    e       = d;
    @(posedge clk);
    model_update(r, rs, v, d);
    #1;
  endtask

  task automatic feed(input logic [15:0] val, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) step(1'b0, 1'b0, 1'b0, val);
      step(1'b0, 1'b0, 1'b1, val);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mse", mse, m_mse);
      chk("mse_valid", 32'(mse_valid), 32'(m_valid));
      chk("converged", 32'(converged), 32'(m_state == 2));
      chk("lock_lost", 32'(lock_lost), 32'(m_lost));
      chk("state", 32'(state), 32'(m_state));
      chk("win_count", 32'(win_count), 32'(m_win));
    end
  end

  initial begin
    int unsigned amp;
    int unsigned sq_a;
    bit          cmode;
    bit          r, rs, v;
    int          val;

    thr_lock   = 32'd1000;
    thr_unlock = 32'd10000;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk_on = 1'b1;
    chk("reset_mse", mse, 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_win", 32'(win_count), 32'd0);
    chk("reset_conv", 32'(converged), 32'd0);

    // Basic window of e=100, pulse two cycles after last sample.
    feed(16'd100, 16, 0);
    idle();
    chk("w1_valid", 32'(mse_valid), 32'd1);
    chk("w1_mse", mse, 32'd10000);
    chk("w1_win", 32'(win_count), 32'd1);
    chk("w1_state", 32'(state), 32'd0);
    idle();
    chk("w1_valid_off", 32'(mse_valid), 32'd0);
    feed(16'd100, 16, 0);
    feed(16'd100, 16, 0);

    feed(16'h8000, 16, 0);
    idle();
    chk("max_mse", mse, 32'd1073741824);

    feed(16'd3, 8, 0);
    feed(16'd4, 8, 0);
    idle();
    chk("mixed_mse", mse, 32'd12);
    chk("skip_done_state", 32'(state), 32'd1);

    // Restart to run the documented lock sequence from a clean count.
    step(1'b0, 1'b1, 1'b0, 16'h0);
    for (int w = 0; w < 6; w++) feed(16'd10, 16, 0);
    idle();
    chk("pre_lock_state", 32'(state), 32'd1);
    feed(16'd10, 16, 0);
    idle();
    chk("lock_conv", 32'(converged), 32'd1);
    chk("lock_state", 32'(state), 32'd2);
    chk("lock_win", 32'(win_count), 32'd7);

    feed(16'd100, 16, 0);
    idle();
    chk("eq_unlock_conv", 32'(converged), 32'd1);
    feed(16'd101, 16, 0);
    idle();
    chk("unlock_mse", mse, 32'd10201);
    chk("unlock_conv", 32'(converged), 32'd0);
    chk("unlock_lost", 32'(lock_lost), 32'd1);
    idle();
    chk("unlock_lost_off", 32'(lock_lost), 32'd0);

    thr_lock = 32'd10000;
    for (int w = 0; w < 3; w++) feed(16'd100, 16, 0);
    idle();
    chk("eq_lock_state", 32'(state), 32'd1);
    thr_lock = 32'd1000;

    feed(16'd100, 16, 2);
    idle();
    chk("sparse_valid", 32'(mse_valid), 32'd1);
    chk("sparse_mse", mse, 32'd10000);

    // Restart mid-window together with en.
    feed(16'd7, 10, 0);
    step(1'b0, 1'b1, 1'b1, 16'd7);
    feed(16'd5, 15, 0);
    idle();
    idle();
    chk("rst_hold_mse", mse, 32'd10000);
    chk("rst_win0", 32'(win_count), 32'd0);
    feed(16'd5, 1, 0);
    idle();
    chk("rst_valid", 32'(mse_valid), 32'd1);
    chk("rst_mse", mse, 32'd25);
    chk("rst_win1", 32'(win_count), 32'd1);
    chk("rst_conv", 32'(converged), 32'd0);

    // In-flight square dropped by a restart on the following cycle.
    step(1'b0, 1'b0, 1'b1, 16'd200);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    feed(16'd1, 16, 0);
    idle();
    chk("inflight_mse", mse, 32'd1);

    // Randomized traffic in regimes of amplitude and thresholds.
    amp   = 10;
    cmode = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (i % 300 == 0) begin
        case ($urandom_range(4, 0))
          0: amp = 4;
          1: amp = 12;
          2: amp = 40;
          3: amp = 150;
          default: amp = 32767;
        endcase
        sq_a  = amp * amp;
        cmode = ($urandom_range(1, 0) == 1);
        thr_lock   = ($urandom_range(2, 0) == 0) ? sq_a : $urandom_range(sq_a, 0);
        thr_unlock = ($urandom_range(2, 0) == 0) ? sq_a : $urandom_range(sq_a, 0);
      end
      r  = ($urandom_range(1499, 0) == 0);
      rs = ($urandom_range(399, 0) == 0);
      v  = ($urandom_range(3, 0) != 0);
      val = cmode ? int'(amp) : int'($urandom_range(2 * amp, 0)) - int'(amp);
      step(r, rs, v, 16'(val));
    end

    repeat (4) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lms_conv_monitor.md
# lms_conv_monitor

Downstream of the 16-tap LMS adaptive filter. Consumes the filter's error sample `e` and computes a windowed mean-square error (MSE) over 2^WIN_LOG2 accepted samples. A lock state machine with hysteresis drives `converged` and a `lock_lost` pulse for system control and debug readout. Single clock domain; no backpressure to the filter.

## Interface
- WIN_LOG2, 4, log2 of window length in samples (window = 16 by default).
- SKIP_WIN, 4, number of windows discarded for lock decisions after reset or restart.
- LOCK_WIN, 3, consecutive below-threshold windows required to lock (≥1).
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- restart  input  1  synchronous soft restart of measurement and lock FSM.
- en  input  1  sample strobe; `e` accepted on cycles with en=1.
- e  input  16  signed error sample from the LMS filter.
- thr_lock  input  32  unsigned MSE lock threshold, sampled at window close.
- thr_unlock  input  32  unsigned MSE unlock threshold, sampled at window close.
- mse  output  32  unsigned mean-square error of last completed window.
- mse_valid  output  1  one-cycle pulse when `mse` updates.
- converged  output  1  high while FSM in LOCKED.
- lock_lost  output  1  one-cycle pulse on LOCKED→UNLOCKED.
- state  output  2  FSM state: 0 WARMUP, 1 UNLOCKED, 2 LOCKED.
- win_count  output  16  completed windows since reset/restart, saturates at 65535.

## Operation
- Stage 1: on en=1, register sq = e*e as 32-bit unsigned (max 2^30, no overflow) and sq_v=1; else sq_v=0.
- Stage 2: on sq_v=1, sample counter (WIN_LOG2 bits) increments; acc (32+WIN_LOG2 bits) += sq.
- Window close (sq_v=1 and counter = 2^WIN_LOG2−1): mse <= (acc+sq) >> WIN_LOG2 (truncation); acc <= 0; counter wraps to 0; mse_valid <= 1; win_count += 1 (saturating).
- FSM, evaluated only at window close using the new MSE value m:
  - WARMUP: skip counter increments; after SKIP_WIN closes → UNLOCKED, lock_cnt=0. With SKIP_WIN=0, reset/restart enters UNLOCKED directly.
  - UNLOCKED: m < thr_lock → lock_cnt+1, else lock_cnt=0. When lock_cnt reaches LOCK_WIN → LOCKED.
  - LOCKED: m > thr_unlock → UNLOCKED, lock_cnt=0, lock_lost pulse. Otherwise stay.
- Comparisons are strict: m == thr_lock does not count; m == thr_unlock keeps lock.
- The threshold relation is not checked. If thr_lock > thr_unlock, the FSM may lock and unlock on alternate windows. This is legal.
- restart=1: clears stage-1 sq_v, acc, counter, skip/lock counters, and win_count. Forces state to WARMUP (or UNLOCKED if SKIP_WIN=0), converged=0, and pulses to 0. mse holds its last value. Sample on en in the same cycle is discarded; restart wins over any window close.
- reset=1: as restart, plus mse=0.

## Timing
- Reset values: mse=0, mse_valid=0, converged=0, lock_lost=0, state=0 (WARMUP), win_count=0.
- Latency: last sample of a window with en=1 in cycle c → mse, mse_valid, state, converged, lock_lost, and win_count are all visible in cycle c+2.
- en may be asserted every cycle or with arbitrary gaps. Output is independent of spacing; only accepted samples count.
- Minimum spacing between mse_valid pulses is 2^WIN_LOG2 cycles.
- converged changes only in the cycle mse_valid is high. lock_lost is coincident with the falling edge of converged.
- Sample accepted in cycle c and restart in cycle c+1: the in-flight sq is dropped.

## Test plan
- Reset, then en=1 for 16 cycles (0..15) with e=100 → mse=10000, mse_valid high in cycle 17 only, win_count=1, state=0. Repeat → pulse every 16 cycles.
- e=−32768 constant → mse=1073741824 exactly, no wrap. Mixed window of 8×3 and 8×4 → mse=(72+128)/16=12 (truncated from 12.5).
- SKIP_WIN=4, LOCK_WIN=3, thr_lock=1000, thr_unlock=10000, e=10 (m=100) → state 1 after 4th pulse, converged=1 and state=2 with 7th pulse.
- From LOCKED: e=100 (m=10000, equal to thr_unlock) → stays locked. Then e=101 (m=10201) → converged=0, lock_lost one-cycle pulse with that mse_valid.
- en asserted every 3rd cycle, e=100 → same mse=10000. mse_valid is 2 cycles after the 16th accepted sample.
- After 10 accepted samples, assert restart together with en → window restarts. Next mse_valid comes 2 cycles after 16 further samples. win_count=1 at that pulse, converged=0, mse holds pre-restart value until then.
